// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, oversampling
// constants and the default data width.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;
  localparam int N_BIT_DEF  = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle
// (high) level so the receiver never sees a false start bit out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk) begin
    if (rst) ff_q <= 2'b11;
    else     ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx_core.sv
// 16x-oversampled UART receiver: mid-bit sampling, LSB-first, stop-bit framing
// check. Define UART_RX_PARITY_EN to add an even-parity bit and parity_err.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int N_BIT   = N_BIT_DEF,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S_tick,
  input  logic             rx,
  output logic [N_BIT-1:0] dout,
  output logic             rx_done_tick,
  output logic             frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;
  localparam int NW = (N_BIT > 1) ? $clog2(N_BIT) : 1;
  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N_BIT - 1);

  logic             rx_s;
  logic [2:0]       state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [NW-1:0]    n_q, n_d;
  logic [N_BIT-1:0] b_q, b_d;
  logic [N_BIT-1:0] dout_q, dout_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             brk_q, brk_d;
  logic             par_q, par_d;
  logic             perr_q, perr_d;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    par_d   = par_q;
    brk_d   = brk_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    // After a framing error the line must return high before a new start
    // edge is accepted, so a held-low break yields one error, not a stream.
    if (rx_s) brk_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s && !brk_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (S_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (S_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s, b_q[N_BIT-1:1]};
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (S_tick) begin
          if (s_q == S_BIT) begin
            s_d     = '0;
            par_d   = rx_s;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (S_tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            dout_d  = b_q;
            ferr_d  = !rx_s;
            brk_d   = !rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_q ^ (^b_q);
            done_d  = rx_s && !perr_d;
`else
            done_d  = rx_s;
`endif
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: frames are pushed as expected results
// when sent and checked against each pulse the receiver produces.
module tb_uart_rx_core;

  localparam int BIT_CLK = 256;

  typedef struct {
    logic [2:0] flags;   // {parity_err, frame_err, rx_done_tick}
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       S_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       perr_w;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  uart_rx_core #(.N_BIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .S_tick       (S_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err   (perr_w)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign perr_w = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (15) @(posedge clk);
      #1 S_tick = 1'b1;
      @(posedge clk);
      #1 S_tick = 1'b0;
    end
  end

  // Scoreboard: every output pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (!rst && (rx_done_tick || frame_err || perr_w)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got flags=%b dout=%h, required no pulse",
                 {perr_w, frame_err, rx_done_tick}, dout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({perr_w, frame_err, rx_done_tick} !== e.flags || dout !== e.data) begin
          n_err++;
          $display("FAIL frame_result: got flags=%b dout=%h, required flags=%b dout=%h",
                   {perr_w, frame_err, rx_done_tick}, dout, e.flags, e.data);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`else
    if (par_b) rx = 1'b1;
`endif
    send_bit(stop_b);
    rx = 1'b1;
  endtask

  task automatic expect_frame(input logic [2:0] flags, input logic [7:0] d);
    exp_t e;
    e.flags = flags;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic idle_bits(input int nb);
    rx = 1'b1;
    repeat (nb * BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({dout, rx_done_tick, frame_err, perr_w} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got dout=%h done=%b ferr=%b perr=%b, required all 0",
               dout, rx_done_tick, frame_err, perr_w);
    end
    #1 rst = 1'b0;
    idle_bits(1);
    n_cmp++;
    if ({dout, rx_done_tick, frame_err} !== 10'd0) begin
      n_err++;
      $display("FAIL idle_after_reset: got dout=%h done=%b ferr=%b, required 0", dout, rx_done_tick, frame_err);
    end
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_missing_pulse: got %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_single;
    expect_frame(3'b001, 8'hA5);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle_bits(2);
    check_drained("single");
  endtask

  task automatic test_back_to_back;
    expect_frame(3'b001, 8'h00);
    expect_frame(3'b001, 8'hFF);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle_bits(2);
    check_drained("back_to_back");
  endtask

  task automatic test_glitch;
    logic [7:0] d0;
    d0 = dout;
    rx = 1'b0;
    repeat (4 * 16) @(posedge clk);
    #1;
    idle_bits(2);
    n_cmp++;
    if (dout !== d0) begin
      n_err++;
      $display("FAIL glitch_dout: got %h, required %h", dout, d0);
    end
    check_drained("glitch");
  endtask

  task automatic test_frame_err;
    expect_frame(3'b010, 8'h3C);
    send_frame(8'h3C, 1'b0, ^8'h3C);
    idle_bits(2);
    check_drained("frame_err");
  endtask

  task automatic test_reset_mid;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({dout, rx_done_tick, frame_err} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got dout=%h done=%b ferr=%b, required 0",
               dout, rx_done_tick, frame_err);
    end
    #1 rst = 1'b0;
    idle_bits(1);
    check_drained("reset_mid_partial");
    expect_frame(3'b001, 8'h81);
    send_frame(8'h81, 1'b1, ^8'h81);
    idle_bits(2);
    check_drained("reset_mid");
  endtask

  task automatic test_break;
    expect_frame(3'b010, 8'h00);
    rx = 1'b0;
    repeat (14 * BIT_CLK) @(posedge clk);
    #1;
    check_drained("break_single_err");
    idle_bits(2);
    n_cmp++;
    if (dout !== 8'h00) begin
      n_err++;
      $display("FAIL break_dout: got %h, required 00", dout);
    end
    expect_frame(3'b001, 8'h5A);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    idle_bits(2);
    check_drained("break_rearm");
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    expect_frame(3'b100, 8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(2);
    check_drained("parity_bad");
    expect_frame(3'b001, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(2);
    check_drained("parity_good");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_break();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
